cacheline_adaptor: RTL

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

---
 rtl/rv32i_types.sv | 12 +
 rtl/cacheline_adaptor.sv | 117 +++++++++++
 2 files changed

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared line/burst types for the LLC memory path.
package rv32i_types;

    localparam int BURST_WIDTH     = 64;
    localparam int BURSTS_PER_LINE = 4;
    localparam int LINE_WIDTH      = BURST_WIDTH * BURSTS_PER_LINE;

    typedef logic [31:0]            rv32i_word;
    typedef logic [LINE_WIDTH-1:0]  llc_cacheline;
    typedef logic [BURST_WIDTH-1:0] llc_burst;

endpackage

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - converts 256-bit line requests into four 64-bit memory beats.
// Optional: CACHELINE_ADAPTOR_RESP_BYPASS_EN drops DONE and signals resp_o with the last beat.
import rv32i_types::*;

module cacheline_adaptor (
    input  logic         clk,
    input  logic         rst,
    input  logic         read_i,
    input  logic         write_i,
    input  rv32i_word    address_i,
    input  llc_cacheline line_i,
    output llc_cacheline line_o,
    output logic         resp_o,
    output logic         read_o,
    output logic         write_o,
    output rv32i_word    address_o,
    output llc_burst     burst_o,
    input  llc_burst     burst_i,
    input  logic         resp_i
);

`ifdef CACHELINE_ADAPTOR_RESP_BYPASS_EN
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
`else
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
`endif

    state_t       state, state_next;
    logic [1:0]   beat_cnt;
    rv32i_word    addr_q;
    llc_cacheline rd_line;
    llc_cacheline wr_line;
    logic         resp_q;
    logic         last_beat;
    logic         accept_rd;
    logic         accept_wr;

    // resp_q blocks acceptance for one cycle after completion so a request
    // still held high while the arbiter reacts to resp_o is not serviced twice.
    assign accept_rd = (state == IDLE) && !resp_q && read_i;
    assign accept_wr = (state == IDLE) && !resp_q && !read_i && write_i;
    assign last_beat = resp_i && (beat_cnt == 2'd3);

    always_comb begin
        state_next = state;
        resp_o     = 1'b0;
        case (state)
            IDLE: begin
                if (accept_rd) begin
                    state_next = READ;
                end else if (accept_wr) begin
                    state_next = WRITE;
                end
            end
            READ, WRITE: begin
                if (last_beat) begin
`ifdef CACHELINE_ADAPTOR_RESP_BYPASS_EN
                    resp_o     = 1'b1;
                    state_next = IDLE;
`else
                    state_next = DONE;
`endif
                end
            end
`ifndef CACHELINE_ADAPTOR_RESP_BYPASS_EN
            DONE: begin
                resp_o     = 1'b1;
                state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= 2'd0;
            addr_q   <= '0;
            rd_line  <= '0;
            wr_line  <= '0;
            resp_q   <= 1'b0;
        end else begin
            state  <= state_next;
            resp_q <= resp_o;
            if (accept_rd || accept_wr) begin
                addr_q   <= address_i;
                beat_cnt <= 2'd0;
            end
            if (accept_wr) begin
                wr_line <= line_i;
            end
            // The counter saturates at 3; the next acceptance clears it.
            if ((state == READ || state == WRITE) && resp_i) begin
                if (state == READ) begin
                    rd_line[BURST_WIDTH*beat_cnt +: BURST_WIDTH] <= burst_i;
                end
                if (beat_cnt != 2'd3) begin
                    beat_cnt <= beat_cnt + 2'd1;
                end
            end
        end
    end

    assign read_o    = (state == READ);
    assign write_o   = (state == WRITE);
    assign address_o = {addr_q[31:5], 5'b0};
    assign burst_o   = wr_line[BURST_WIDTH*beat_cnt +: BURST_WIDTH];

`ifdef CACHELINE_ADAPTOR_RESP_BYPASS_EN
    assign line_o = (state == READ && last_beat) ? {burst_i, rd_line[LINE_WIDTH-BURST_WIDTH-1:0]}
                                                 : rd_line;
`else
    assign line_o = rd_line;
`endif

endmodule
